demux_pipe: RTL
===============

Name: demux_pipe

Overview:
- Split counterpart of the merge pipe: accepts one 128-bit enq stream and steers each beat to a local output (out) or a forward output (forward).
- Steering is by a tag field in the payload.
- Each destination has its own 2-entry registered FIFO, so a stalled destination does not drop data.
- Sits where a ring/chain node peels off traffic addressed to itself and passes the rest downstream.

Parameters:
- WIDTH, 128, payload width in bits.
- TAG_W, 4, width of tag field at v[WIDTH-1 -: TAG_W].
- LOCAL_TAG, 0, tag value routed to out; any other value routes to forward.
- DEPTH, 2, entries per destination FIFO (power of two, ≥2).

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- in$enq__ENA  input  1  beat offered and accepted (asserted only when in$enq__RDY=1)
- in$enq$v  input  WIDTH  payload
- in$enq__RDY  output  1  block can accept a beat this cycle
- out$enq__ENA  output  1  local beat transferred this cycle
- out$enq$v  output  WIDTH  local payload
- out$enq__RDY  input  1  local sink can take a beat
- forward$enq__ENA  output  1  forwarded beat transferred this cycle
- forward$enq$v  output  WIDTH  forwarded payload
- forward$enq__RDY  input  1  downstream can take a beat
- local_count  output  16  beats delivered on out since reset, wraps
- fwd_count  output  16  beats delivered on forward since reset, wraps

Behaviour:
- Reset (RST=1 at CLK edge):
  - both FIFOs empty; read/write pointers and occupancy counts = 0
  - local_count = fwd_count = 0
  - out$enq__ENA = forward$enq__ENA = 0
  - in$enq__RDY = 1 in the cycle after reset deasserts
- Reset mid-operation discards all buffered beats; no ENA is asserted in the reset cycle or the following one.
- Handshake convention:
  - ENA is asserted only when the matching RDY is high; ENA=1 means the transfer happens this cycle.
  - Outputs never assert ENA while their RDY is 0.
- Routing:
  - sel_local = (in$enq$v[WIDTH-1 -: TAG_W] == LOCAL_TAG).
  - On in$enq__ENA, the beat is written into the local FIFO if sel_local, else into the forward FIFO; it is never written to both.
- in$enq__RDY = !full_local && !full_fwd.
  - No combinational path from in$enq$v to in$enq__RDY.
  - A full destination therefore stalls both routes (head-of-line blocking).
- Outputs:
  - out$enq__ENA = !empty_local && out$enq__RDY.
  - out$enq$v = head entry of local FIFO; value is don't-care when empty, driven 0 for determinism.
  - Forward output follows the same rules against the forward FIFO.
- Latency: a beat accepted at edge N is presentable at edge N+1 (1-cycle minimum).
- Throughput: 1 beat/cycle sustained into either destination while its RDY stays high.
- Occupancy update per FIFO each cycle:
  - write only → count+1
  - read only → count−1
  - both → unchanged
  - Simultaneous write and read while count=DEPTH cannot occur (RDY gating).
  - Read while empty cannot occur.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Counters increment by 1 on each out/forward ENA and wrap 0xFFFF → 0x0000.
- Ordering: beats to the same destination leave in arrival order; no ordering guarantee across destinations.

Decomposition:
- Shared package:
  - WIDTH/TAG_W defaults
  - tag-field extraction function
  - LOCAL_TAG default constant
- One natural sub-module: fifo_n_base.
  - Parameterised WIDTH/DEPTH synchronous FIFO with enq/deq/full/empty/head ports.
  - Instantiated twice (local, forward).
- Routing and counters stay in demux_pipe.

Test Plan:
- Reset then idle:
  - Stimulus: RST=1 for 2 cycles, then RST=0.
  - Response: in$enq__RDY=1, both ENAs 0, both counts 0.
- Local routing:
  - Stimulus: enq v=0x0...0AB (tag 0), both sink RDYs=1.
  - Response: next cycle out$enq__ENA=1 with v=0x0...0AB; forward$enq__ENA stays 0; local_count=1.
- Forward routing, back-to-back:
  - Stimulus: 4 consecutive beats with tag 3, values 1..4.
  - Response: forward$enq__ENA high for 4 cycles starting one cycle later, values 1,2,3,4 in order; fwd_count=4.
- Backpressure/full:
  - Stimulus: out$enq__RDY=0; enq 2 tag-0 beats.
  - Response: in$enq__RDY drops to 0 after the 2nd beat.
  - Stimulus: raise out$enq__RDY.
  - Response: beats drain in order, in$enq__RDY returns to 1 the cycle after the first drain.
- Simultaneous enq/deq:
  - Stimulus: local FIFO holds 1 beat, RDY=1, new tag-0 beat enqueued the same cycle.
  - Response: occupancy stays 1, output sequence is old then new.
- Reset mid-stream:
  - Stimulus: 2 forward beats buffered, forward RDY=0, RST pulsed 1 cycle, then forward RDY=1.
  - Response: no forward ENA occurs and fwd_count=0.

Source files
------------

// File: rtl/demux_pipe_pkg.sv
// Shared defaults and helpers for the demux pipe and its destination FIFOs.
package demux_pipe_pkg;

  localparam int unsigned DefWidth    = 128;
  localparam int unsigned DefTagW     = 4;
  localparam int unsigned DefLocalTag = 0;
  localparam int unsigned DefDepth    = 2;

  // Destination of a beat, decided from its tag field.
  typedef enum logic {
    RouteFwd   = 1'b0,
    RouteLocal = 1'b1
  } route_e;

  // Tag field of a beat at the default payload geometry.
  function automatic logic [DefTagW-1:0] tag_of(input logic [DefWidth-1:0] v);
    return v[DefWidth-1 -: DefTagW];
  endfunction

endpackage

// File: rtl/fifo_n_base.sv
// Registered synchronous FIFO with enq/deq strobes and a head-of-queue view.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_n_base #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  // Head is forced to zero when empty so idle outputs are deterministic.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy next-state: write and read in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_data;
  end

endmodule

// File: rtl/demux_pipe.sv
// Steers each incoming beat to the local or forward output by its tag field.
// Each destination has its own small FIFO; a full one stalls the input.
module demux_pipe
  import demux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned TAG_W     = DefTagW,
  parameter int unsigned LOCAL_TAG = DefLocalTag,
  parameter int unsigned DEPTH     = DefDepth
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  output logic             out_enq__ENA,
  output logic [WIDTH-1:0] out_enq_v,
  input  logic             out_enq__RDY,
  output logic             forward_enq__ENA,
  output logic [WIDTH-1:0] forward_enq_v,
  input  logic             forward_enq__RDY,
  output logic [15:0]      local_count,
  output logic [15:0]      fwd_count
);

  route_e     route;
  logic       enq_local, enq_fwd;
  logic       full_local, full_fwd;
  logic       empty_local, empty_fwd;
  logic [15:0] local_count_q, fwd_count_q;

  // Routing decision from the tag field alone.
  always_comb begin
    route = RouteFwd;
    if (in_enq_v[WIDTH-1 -: TAG_W] == TAG_W'(LOCAL_TAG)) route = RouteLocal;
  end

  assign enq_local = in_enq__ENA && (route == RouteLocal);
  assign enq_fwd   = in_enq__ENA && (route == RouteFwd);

  // Ready depends only on FIFO state, never on the offered payload.
  assign in_enq__RDY = !full_local && !full_fwd;

  // Outputs are held off while reset is asserted so stale beats never leak.
  assign out_enq__ENA     = !RST && !empty_local && out_enq__RDY;
  assign forward_enq__ENA = !RST && !empty_fwd && forward_enq__RDY;

  assign local_count = local_count_q;
  assign fwd_count   = fwd_count_q;

  fifo_n_base #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_local (
    .clk      (CLK),
    .rst      (RST),
    .enq      (enq_local),
    .enq_data (in_enq_v),
    .deq      (out_enq__ENA),
    .head     (out_enq_v),
    .full     (full_local),
    .empty    (empty_local)
  );

  fifo_n_base #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_fwd (
    .clk      (CLK),
    .rst      (RST),
    .enq      (enq_fwd),
    .enq_data (in_enq_v),
    .deq      (forward_enq__ENA),
    .head     (forward_enq_v),
    .full     (full_fwd),
    .empty    (empty_fwd)
  );

  // Delivered-beat counters, wrapping at 16 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      local_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      if (out_enq__ENA)     local_count_q <= local_count_q + 16'd1;
      if (forward_enq__ENA) fwd_count_q   <= fwd_count_q + 16'd1;
    end
  end

endmodule
